// File: rtl/regfile_write_queue_if.sv
// Bus bundle for regfile_write_queue: request side, register file write port,
// pending-write lookup port and occupancy status.
interface regfile_write_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              In_Valid;
    logic              In_Ready;
    logic [ADDR_W-1:0] In_Adr;
    logic [DATA_W-1:0] In_Data;
    logic              Hold;
    logic              WEn;
    logic [ADDR_W-1:0] Write_Adr;
    logic [DATA_W-1:0] Write_Data;
    logic [ADDR_W-1:0] Lookup_Adr;
    logic              Lookup_Hit;
    logic [DATA_W-1:0] Lookup_Data;
    logic [CNT_W-1:0]  Count;
    logic              Empty;
    logic              Full;

    modport master (
        output In_Valid, In_Adr, In_Data, Hold, Lookup_Adr,
        input  In_Ready, WEn, Write_Adr, Write_Data, Lookup_Hit, Lookup_Data,
               Count, Empty, Full
    );

    modport slave (
        input  In_Valid, In_Adr, In_Data, Hold, Lookup_Adr,
        output In_Ready, WEn, Write_Adr, Write_Data, Lookup_Hit, Lookup_Data,
               Count, Empty, Full
    );
endinterface

// File: rtl/regfile_write_queue.sv
// In-order write-back queue feeding the register file write port, with a
// forwarding lookup of pending writes. Optional macro: ZERO_REG_DISCARD_EN.
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input logic                  Clock,
    input logic                  Reset,
    regfile_write_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] adr_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cnt_q;

    logic empty, full, push, enq, pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign push  = bus.In_Valid && !full;

`ifdef ZERO_REG_DISCARD_EN
    // r0 writes complete the handshake but are dropped on the floor
    assign enq = push && (bus.In_Adr != '0);
`else
    assign enq = push;
`endif

    // Gating with Reset keeps the register file untouched in the reset cycle
    assign pop = !empty && !bus.Hold && !Reset;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
        end else begin
            if (enq) begin
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && enq) begin
            adr_q[wr_ptr]  <= bus.In_Adr;
            data_q[wr_ptr] <= bus.In_Data;
        end
    end

    assign bus.WEn        = pop;
    assign bus.Write_Adr  = empty ? '0 : adr_q[rd_ptr];
    assign bus.Write_Data = empty ? '0 : data_q[rd_ptr];
    assign bus.Count      = cnt_q;
    assign bus.Empty      = empty;
    assign bus.Full       = full;
    assign bus.In_Ready   = !full;

    // Walk oldest -> youngest so the last match wins (newest pending value)
    logic [PTR_W-1:0]  idx;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    always_comb begin
        idx      = '0;
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (vld_q[idx] && (adr_q[idx] == bus.Lookup_Adr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
`ifdef ZERO_REG_DISCARD_EN
        if (bus.Lookup_Adr == '0) begin
            hit      = 1'b0;
            hit_data = '0;
        end
`endif
    end

    assign bus.Lookup_Hit  = hit;
    assign bus.Lookup_Data = hit_data;
endmodule
